// File: rtl/risc_mem_arb_pkg.sv
// Shared types and helpers for the multi-channel memory arbiter: FSM state encoding,
// counter/pointer width helpers and parameter-range messages.
package risc_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam string MSG_NCH    = "risc_mem_arb: NCH must be in 1..8";
    localparam string MSG_RD_LAT = "risc_mem_arb: RD_LAT must be in 1..8";
    localparam string MSG_WIDTH  = "risc_mem_arb: DATA_W and ADDR_W must be at least 1";

    // Width of the WAIT down-counter (CNT_W); it must hold RD_LAT itself.
    function automatic int cnt_w(input int rd_lat);
        return $clog2(rd_lat + 1);
    endfunction

    // Channel index width; a single channel still needs a 1-bit pointer.
    function automatic int ptr_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/risc_mem_arb_if.sv
// Requester-side bus of the shared memory: per-channel req/we/addr/wdata in,
// per-channel ack plus shared rdata/busy out.
interface risc_mem_arb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NCH    = 2
);
    logic [NCH-1:0]        req;
    logic [NCH-1:0]        we;
    logic [NCH*ADDR_W-1:0] addr;
    logic [NCH*DATA_W-1:0] wdata;
    logic [NCH-1:0]        ack;
    logic [DATA_W-1:0]     rdata;
    logic                  busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, busy
    );
endinterface

// File: rtl/risc_mem_arb_rr.sv
// Combinational NCH-way round-robin pick: first asserted req at or above ptr_i, wrapping.
// Zero latency; no backpressure, the caller decides when the pick is consumed.
import risc_mem_pkg::*;

module risc_rr_arb #(
    parameter int NCH   = 2,
    parameter int PTR_W = ptr_w(NCH)
) (
    input  logic [NCH-1:0]   req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NCH-1:0]   gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             vld_o
);

    always_comb begin
        int sel;
        sel   = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            sel = (int'(ptr_i) + k) % NCH;
            if (!vld_o && req_i[sel]) begin
                vld_o      = 1'b1;
                gnt_o[sel] = 1'b1;
                idx_o      = PTR_W'(sel);
            end
        end
    end

endmodule

// File: rtl/risc_mem_arb.sv
// Shared single-port word memory behind a round-robin req/ack arbiter; write acks at grant+1,
// read acks at grant+RD_LAT. Requesters stall on ack; one request in flight, others simply wait.
import risc_mem_pkg::*;

module risc_mem_arb #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NCH    = 2,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            proc_rst,
    risc_mem_arb_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = cnt_w(RD_LAT);
    localparam int PTR_W = ptr_w(NCH);

    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("%s", MSG_NCH);
    end
    if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_lat
        $error("%s", MSG_RD_LAT);
    end
    if (DATA_W < 1 || ADDR_W < 1) begin : g_bad_width
        $error("%s", MSG_WIDTH);
    end

    state_e              state_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [NCH-1:0]      gnt_oh_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NCH-1:0]      ack_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                busy_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [NCH-1:0]      pick_gnt;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_vld;
    logic                last_wait;
    logic                mem_we;

    risc_rr_arb #(
        .NCH   (NCH),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i (bus.req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    assign rr_ptr_d  = (int'(pick_idx) == NCH - 1) ? '0 : pick_idx + 1'b1;
    assign cnt_d     = cnt_q - 1'b1;
    assign last_wait = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));
    // Commit only on the final WAIT edge, so a reset during WAIT drops the write.
    assign mem_we    = last_wait && we_q;

    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            gnt_oh_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        state_q  <= S_WAIT;
                        rr_ptr_q <= rr_ptr_d;
                        gnt_oh_q <= pick_gnt;
                        we_q     <= bus.we[pick_idx];
                        addr_q   <= bus.addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        wdata_q  <= bus.wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        cnt_q    <= bus.we[pick_idx] ? CNT_W'(1) : CNT_W'(RD_LAT);
                        busy_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (last_wait) begin
                        state_q <= S_DONE;
                        ack_q   <= gnt_oh_q;
                        if (!we_q) begin
                            rdata_q <= mem_q[addr_q];
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; only the registered control path is.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_risc_mem_arb.sv
// Directed bench: instance A (NCH=3, RD_LAT=1, 16x32) and instance B (NCH=2, RD_LAT=4, 32x256).
module tb_risc_mem_arb;

    localparam int RD_LAT_A = 1;
    localparam int RD_LAT_B = 4;

    logic clk = 1'b0;
    logic proc_rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    risc_mem_arb_if #(.DATA_W(16), .ADDR_W(5), .NCH(3)) a_if ();
    risc_mem_arb_if #(.DATA_W(32), .ADDR_W(8), .NCH(2)) b_if ();

    risc_mem_arb #(.DATA_W(16), .ADDR_W(5), .NCH(3), .RD_LAT(RD_LAT_A)) u_a (
        .clk      (clk),
        .proc_rst (proc_rst),
        .bus      (a_if)
    );

    risc_mem_arb #(.DATA_W(32), .ADDR_W(8), .NCH(2), .RD_LAT(RD_LAT_B)) u_b (
        .clk      (clk),
        .proc_rst (proc_rst),
        .bus      (b_if)
    );

    typedef struct {
        bit          sel;
        int          ch;
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t        vt [14];
    logic [2:0]  got_ack [8];
    logic [31:0] got_rd  [8];
    int          got_cyc [8];
    int          got_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] get_ack(input bit sel);
        return sel ? 32'(b_if.ack) : 32'(a_if.ack);
    endfunction

    function automatic logic [31:0] get_busy(input bit sel);
        return sel ? 32'(b_if.busy) : 32'(a_if.busy);
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? b_if.rdata : 32'(a_if.rdata);
    endfunction

    task automatic drive(input bit sel, input int ch, input bit r, input bit w,
                         input logic [7:0] ad, input logic [31:0] wd);
        if (sel) begin
            b_if.req[ch]            = r;
            b_if.we[ch]             = w;
            b_if.addr[ch*8 +: 8]    = ad;
            b_if.wdata[ch*32 +: 32] = wd;
        end else begin
            a_if.req[ch]            = r;
            a_if.we[ch]             = w;
            a_if.addr[ch*5 +: 5]    = ad[4:0];
            a_if.wdata[ch*16 +: 16] = wd[15:0];
        end
    endtask

    // One request from a single channel, held until its ack, then released.
    task automatic do_txn(input vec_t v, input string tag);
        int          n;
        logic [31:0] ackv;
        logic        bsy_ok;
        @(posedge clk);
        #1;
        drive(v.sel, v.ch, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk({tag, " busy before grant"}, get_busy(v.sel), 32'd0);
        @(posedge clk);
        n      = 0;
        ackv   = '0;
        bsy_ok = 1'b1;
        while (ackv == 0 && n < 20) begin
            @(negedge clk);
            n++;
            ackv = get_ack(v.sel);
            if (get_busy(v.sel) != 32'd1) bsy_ok = 1'b0;
        end
        chk({tag, " ack latency"}, 32'(n - 1), 32'(v.exp_lat));
        chk({tag, " ack channel"}, ackv, 32'd1 << v.ch);
        chk({tag, " rdata at ack"}, get_rdata(v.sel), v.exp_rd);
        chk({tag, " busy through WAIT/DONE"}, 32'(bsy_ok), 32'd1);
        @(posedge clk);
        #1;
        drive(v.sel, v.ch, 1'b0, 1'b0, 8'd0, 32'd0);
        @(negedge clk);
        chk({tag, " ack after DONE"}, get_ack(v.sel), 32'd0);
        chk({tag, " busy after DONE"}, get_busy(v.sel), 32'd0);
        chk({tag, " rdata held"}, get_rdata(v.sel), v.exp_rd);
    endtask

    // Collect acks on instance A; optionally drop each acked channel's req at the sampling edge.
    task automatic watch_a(input int nacks, input bit drop, input string tag);
        logic [2:0] dropm;
        got_n = 0;
        for (int c = 0; c < 60 && got_n < nacks; c++) begin
            @(negedge clk);
            dropm = '0;
            if (a_if.ack != 3'b000) begin
                got_ack[got_n] = a_if.ack;
                got_rd[got_n]  = 32'(a_if.rdata);
                got_cyc[got_n] = c;
                got_n++;
                if (drop) dropm = a_if.ack;
            end
            @(posedge clk);
            #1;
            a_if.req = a_if.req & ~dropm;
        end
        chk({tag, " ack count"}, 32'(got_n), 32'(nacks));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_ack;

        vt[0]  = '{1'b0, 0, 1'b1, 8'd3,   32'h0000BEEF, 32'h00000000, 1};
        vt[1]  = '{1'b0, 0, 1'b0, 8'd3,   32'h00000000, 32'h0000BEEF, RD_LAT_A};
        vt[2]  = '{1'b0, 2, 1'b1, 8'd0,   32'h00000A00, 32'h0000BEEF, 1};
        vt[3]  = '{1'b0, 1, 1'b1, 8'd1,   32'h00000B01, 32'h0000BEEF, 1};
        vt[4]  = '{1'b0, 2, 1'b1, 8'd2,   32'h00000C02, 32'h0000BEEF, 1};
        vt[5]  = '{1'b0, 1, 1'b0, 8'd0,   32'h00000000, 32'h00000A00, RD_LAT_A};
        vt[6]  = '{1'b1, 0, 1'b1, 8'd7,   32'h00001234, 32'h00000000, 1};
        vt[7]  = '{1'b1, 1, 1'b0, 8'd7,   32'h00000000, 32'h00001234, RD_LAT_B};
        vt[8]  = '{1'b1, 0, 1'b1, 8'd255, 32'hDEADBEEF, 32'h00001234, 1};
        vt[9]  = '{1'b1, 1, 1'b1, 8'd127, 32'h0000CAFE, 32'h00001234, 1};
        vt[10] = '{1'b1, 0, 1'b1, 8'd0,   32'h00000000, 32'h00001234, 1};
        vt[11] = '{1'b1, 1, 1'b0, 8'd255, 32'h00000000, 32'hDEADBEEF, RD_LAT_B};
        vt[12] = '{1'b1, 0, 1'b0, 8'd127, 32'h00000000, 32'h0000CAFE, RD_LAT_B};
        vt[13] = '{1'b1, 1, 1'b0, 8'd0,   32'h00000000, 32'h00000000, RD_LAT_B};

        a_if.req = '0; a_if.we = '0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = '0; b_if.we = '0; b_if.addr = '0; b_if.wdata = '0;

        #2 proc_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset A ack", get_ack(1'b0), 32'd0);
        chk("reset A busy", get_busy(1'b0), 32'd0);
        chk("reset A rdata", get_rdata(1'b0), 32'd0);
        chk("reset B ack", get_ack(1'b1), 32'd0);
        chk("reset B busy", get_busy(1'b1), 32'd0);
        chk("reset B rdata", get_rdata(1'b1), 32'd0);
        proc_rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_txn(vt[i], $sformatf("vec%0d", i));
        end

        // Rotation: contents survive reset, pointer restarts at channel 0.
        @(posedge clk);
        #1 proc_rst = 1'b0;
        @(negedge clk);
        proc_rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 0, 1'b1, 1'b0, 8'd0, 32'd0);
        drive(1'b0, 1, 1'b1, 1'b0, 8'd1, 32'd0);
        drive(1'b0, 2, 1'b1, 1'b0, 8'd2, 32'd0);
        watch_a(6, 1'b0, "rotation");
        a_if.req = '0;
        for (int k = 0; k < got_n; k++) begin
            chk($sformatf("rotation grant %0d", k), 32'(got_ack[k]), 32'd1 << (k % 3));
            chk($sformatf("rotation rdata %0d", k), got_rd[k],
                (k % 3 == 0) ? 32'h0A00 : (k % 3 == 1) ? 32'h0B01 : 32'h0C02);
            if (k > 0)
                chk($sformatf("rotation spacing %0d", k), 32'(got_cyc[k] - got_cyc[k-1]),
                    32'(RD_LAT_A + 2));
        end
        repeat (2) @(posedge clk);

        // Channel 0 served last, so channel 1 wins the simultaneous pair and its write is seen.
        do_txn('{1'b0, 0, 1'b0, 8'd0, 32'h0, 32'h00000A00, RD_LAT_A}, "pre-pair");
        @(posedge clk);
        #1;
        drive(1'b0, 0, 1'b1, 1'b0, 8'd9, 32'd0);
        drive(1'b0, 1, 1'b1, 1'b1, 8'd9, 32'h00AA);
        watch_a(2, 1'b1, "pair");
        a_if.req = '0;
        chk("pair first grant", 32'(got_ack[0]), 32'b010);
        chk("pair second grant", 32'(got_ack[1]), 32'b001);
        chk("pair read after write", got_rd[1], 32'h00AA);

        // Reset while a write sits in WAIT: write dropped, no ack, pointer back to 0.
        do_txn('{1'b0, 0, 1'b1, 8'd2, 32'h0001, 32'h000000AA, 1}, "pre-reset");
        @(posedge clk);
        #1;
        drive(1'b0, 0, 1'b1, 1'b1, 8'd2, 32'h5555);
        @(posedge clk);
        #2;
        chk("abort busy in WAIT", get_busy(1'b0), 32'd1);
        proc_rst = 1'b0;
        #1;
        chk("abort ack", get_ack(1'b0), 32'd0);
        chk("abort busy", get_busy(1'b0), 32'd0);
        chk("abort rdata", get_rdata(1'b0), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 8'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        proc_rst = 1'b1;
        saw_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_if.ack != 3'b000) saw_ack = 1'b1;
        end
        chk("no ack for aborted write", 32'(saw_ack), 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 0, 1'b1, 1'b0, 8'd2, 32'd0);
        drive(1'b0, 1, 1'b1, 1'b0, 8'd2, 32'd0);
        watch_a(2, 1'b1, "post-reset");
        a_if.req = '0;
        chk("post-reset first grant", 32'(got_ack[0]), 32'b001);
        chk("post-reset dropped write", got_rd[0], 32'h0001);
        chk("post-reset second grant", 32'(got_ack[1]), 32'b010);
        chk("post-reset second read", got_rd[1], 32'h0001);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
